ldpc_dec_out_serializer: RTL and testbench



---
 rtl/ldpc_dec_pkg.sv | 18 +
 rtl/ldpc_word_fifo.sv | 50 +++++
 rtl/ldpc_dec_out_serializer.sv | 157 +++++++++++++++
 tb/tb_ldpc_dec_out_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_dec_pkg.sv
// Shared decoder constants for the LDPC output path.
// Values must track Decoder_Parameters.v.
package ldpc_dec_pkg;

  localparam int ZC              = 32;
  localparam int DEC_OUT_LIFTING = 16;
  localparam int BLK_NUM         = 8;
  localparam int WORDS_23        = 4;
  localparam int WORDS_78        = 2;

  localparam logic [2:0] ILS_23 = 3'd1;
  localparam logic [2:0] ILS_78 = 3'd2;

  typedef logic [0:0] ser_state_t;
  localparam ser_state_t ST_IDLE = 1'b0;
  localparam ser_state_t ST_SEND = 1'b1;

endpackage

// File: rtl/ldpc_word_fifo.sv
// Single-clock word FIFO with fall-through head.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ldpc_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import ldpc_dec_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ldpc_dec_out_serializer.sv
// Buffers decoded LDPC words, tags them with block framing and
// serialises them LSB beat first onto a valid/ready stream.
module ldpc_dec_out_serializer #(
  parameter int ZC              = ldpc_dec_pkg::ZC,
  parameter int DEC_OUT_LIFTING = ldpc_dec_pkg::DEC_OUT_LIFTING,
  parameter int OUT_W           = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int WORDS_23        = ldpc_dec_pkg::WORDS_23,
  parameter int WORDS_78        = ldpc_dec_pkg::WORDS_78,
  parameter int BLK_NUM         = ldpc_dec_pkg::BLK_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  iLs,
  input  logic                        dec_valid,
  input  logic [2:0]                  dec_valid_cnt,
  input  logic [ZC*DEC_OUT_LIFTING-1:0] dec_data,
  output logic [OUT_W-1:0]            m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic [2:0]                  m_tuser,
  output logic                        ovf,
  output logic                        mode_err,
  output logic                        blk_done,
  output logic                        done_all
);
  import ldpc_dec_pkg::*;

  localparam int IN_W  = ZC * DEC_OUT_LIFTING;
  localparam int BEATS = IN_W / OUT_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAXW  = (WORDS_23 > WORDS_78) ? WORDS_23 : WORDS_78;
  localparam int WCW   = $clog2(MAXW + 1);
  localparam int EW    = IN_W + 4;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BKW   = $clog2(BLK_NUM + 1);

  logic [WCW-1:0]               wcnt;
  logic [WCW-1:0]               words_q;
  logic [WCW-1:0]               words_cur;
  logic                         mode_ok;
  logic                         word_in;
  logic                         word_last;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CW-1:0]                fifo_count;
  logic [EW-1:0]                fifo_dout;
  ser_state_t                   state;
  logic [BEATS-1:0][OUT_W-1:0]  sreg;
  logic [BCW-1:0]               bcnt;
  logic                         cur_last;
  logic [2:0]                   cur_user;
  logic                         hs;
  logic                         end_of_word;
  logic [BKW-1:0]               blk_cnt;

  // Rate is only looked at on the first word of a block; later words reuse the latched count.
  always_comb begin
    words_cur = words_q;
    mode_ok   = 1'b1;
    if (wcnt == '0) begin
      mode_ok = 1'b0;
      if (iLs == ILS_23) begin
        words_cur = WCW'(WORDS_23);
        mode_ok   = 1'b1;
      end else if (iLs == ILS_78) begin
        words_cur = WCW'(WORDS_78);
        mode_ok   = 1'b1;
      end
    end
  end

  assign word_in     = dec_valid && !done_all && mode_ok;
  assign word_last   = (wcnt == words_cur - 1'b1);
  assign hs          = m_tvalid && m_tready;
  assign end_of_word = hs && (bcnt == BCW'(BEATS - 1));
  assign fifo_pop    = ((state == ST_IDLE) && !fifo_empty) ||
                       (end_of_word && (fifo_count != '0));
  assign fifo_push   = word_in && (!fifo_full || fifo_pop);

  ldpc_word_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({dec_data, dec_valid_cnt, word_last}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Dropped words still advance wcnt so later blocks keep their framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      words_q  <= '0;
      ovf      <= 1'b0;
      mode_err <= 1'b0;
    end else if (dec_valid && !done_all) begin
      if (!mode_ok) begin
        mode_err <= 1'b1;
      end else begin
        if (wcnt == '0) words_q <= words_cur;
        wcnt <= word_last ? '0 : wcnt + 1'b1;
        if (!fifo_push) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      bcnt     <= '0;
      cur_last <= 1'b0;
      cur_user <= '0;
    end else if (fifo_pop) begin
      state    <= ST_SEND;
      sreg     <= fifo_dout[EW-1:4];
      cur_user <= fifo_dout[3:1];
      cur_last <= fifo_dout[0];
      bcnt     <= '0;
    end else if (end_of_word) begin
      state <= ST_IDLE;
      bcnt  <= '0;
    end else if (hs) begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_done <= 1'b0;
      done_all <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      blk_done <= hs && m_tlast;
      if (hs && m_tlast) begin
        blk_cnt <= blk_cnt + 1'b1;
        if (blk_cnt == BKW'(BLK_NUM - 1)) done_all <= 1'b1;
      end
    end
  end

  assign m_tvalid = (state == ST_SEND);
  assign m_tdata  = sreg[bcnt];
  assign m_tuser  = cur_user;
  assign m_tlast  = m_tvalid && cur_last && (bcnt == BCW'(BEATS - 1));

endmodule

// File: tb/tb_ldpc_dec_out_serializer.sv
// Directed bench for ldpc_dec_out_serializer: framing, stream order,
// backpressure, overflow, mode error and mid-stream reset.
module tb_ldpc_dec_out_serializer;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int BEATS = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        iLs = '0;
  logic              dec_valid = 1'b0;
  logic [2:0]        dec_valid_cnt = '0;
  logic [IN_W-1:0]   dec_data = '0;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic [2:0]        m_tuser;
  logic              ovf;
  logic              mode_err;
  logic              blk_done;
  logic              done_all;

  int checks = 0;
  int passes = 0;
  int readyMode = 0;
  int cyc = 0;
  int blkDoneCnt = 0;
  int tlastCnt = 0;
  int lastTlastCyc = -10;
  int lastBlkDoneCyc = -20;
  int stallCnt = 0;
  logic        prevStall = 1'b0;
  logic [68:0] prevBus = '0;

  logic [OUT_W-1:0] capData[$];
  logic             capLast[$];
  logic [2:0]       capUser[$];
  logic [OUT_W-1:0] expData[$];
  logic             expLast[$];
  logic [2:0]       expUser[$];

  ldpc_dec_out_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .iLs           (iLs),
    .dec_valid     (dec_valid),
    .dec_valid_cnt (dec_valid_cnt),
    .dec_data      (dec_data),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tuser       (m_tuser),
    .ovf           (ovf),
    .mode_err      (mode_err),
    .blk_done      (blk_done),
    .done_all      (done_all)
  );

  always #5 clk = ~clk;

  // Sink ready pattern: 0 = stalled, 1 = always ready, 2 = toggling.
  always @(posedge clk) begin
    #2;
    if (readyMode == 0)      m_tready = 1'b0;
    else if (readyMode == 1) m_tready = 1'b1;
    else                     m_tready = ~m_tready;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prevStall) begin
        stallCnt++;
        checkOutput("stallHold", {59'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, {59'd0, prevBus});
      end
      if (m_tvalid && m_tready) begin
        capData.push_back(m_tdata);
        capLast.push_back(m_tlast);
        capUser.push_back(m_tuser);
        if (m_tlast) begin
          tlastCnt++;
          lastTlastCyc = cyc;
        end
      end
      if (blk_done) begin
        blkDoneCnt++;
        lastBlkDoneCyc = cyc;
      end
    end
    prevStall = m_tvalid && !m_tready && !rst;
    prevBus   = {m_tvalid, m_tuser, m_tlast, m_tdata};
  end

  function automatic logic [IN_W-1:0] mkWord(input int k);
    logic [IN_W-1:0] w;
    logic [7:0]      bv;
    w = '0;
    for (int b = 0; b < BEATS; b++) begin
      bv = 8'(k * 16 + b);
      for (int j = 0; j < OUT_W / 8; j++) w[b*OUT_W + j*8 +: 8] = bv;
    end
    return w;
  endfunction

  task automatic expectWord(input int k, input logic [2:0] user, input logic last);
    logic [7:0] bv;
    for (int b = 0; b < BEATS; b++) begin
      bv = 8'(k * 16 + b);
      expData.push_back({8{bv}});
      expLast.push_back(last && (b == BEATS - 1));
      expUser.push_back(user);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ils, input logic [2:0] idx, input int k);
    iLs           = ils;
    dec_valid_cnt = idx;
    dec_data      = mkWord(k);
    dec_valid     = 1'b1;
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
  endtask

  task automatic waitBeats(input int n, input int budget);
    int c;
    c = 0;
    while (capData.size() < n && c < budget) begin
      idle(1);
      c++;
    end
    if (capData.size() < n) checkOutput("beatTimeout", capData.size(), n);
  endtask

  task automatic clearQueues();
    capData.delete(); capLast.delete(); capUser.delete();
    expData.delete(); expLast.delete(); expUser.delete();
    tlastCnt = 0;
    blkDoneCnt = 0;
    stallCnt = 0;
  endtask

  task automatic compareBeats(input string tag);
    int n;
    checkOutput({tag, "_count"}, capData.size(), expData.size());
    n = (capData.size() < expData.size()) ? capData.size() : expData.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), capData[i], expData[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), capLast[i], expLast[i]);
      checkOutput($sformatf("%s_user%0d", tag, i), capUser[i], expUser[i]);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clearQueues();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, m_tvalid, 0);
    checkOutput({tag, "_tlast"}, m_tlast, 0);
    checkOutput({tag, "_tdata"}, m_tdata, 0);
    checkOutput({tag, "_tuser"}, m_tuser, 0);
    checkOutput({tag, "_ovf"}, ovf, 0);
    checkOutput({tag, "_modeErr"}, mode_err, 0);
    checkOutput({tag, "_blkDone"}, blk_done, 0);
    checkOutput({tag, "_doneAll"}, done_all, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    idle(3);
    checkIdleOutputs("reset");
    checkOutput("reset_wcnt", dut.wcnt, 0);
    rst = 1'b0;

    // Rate 2/3, one block of four words.
    readyMode = 1;
    idle(2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'd1, 3'd0, k);
      expectWord(k, 3'd0, k == 3);
    end
    waitBeats(32, 200);
    idle(3);
    compareBeats("r23");
    checkOutput("r23_tlastCnt", tlastCnt, 1);
    checkOutput("r23_blkDoneCnt", blkDoneCnt, 1);
    checkOutput("r23_blkDoneDelay", lastBlkDoneCyc - lastTlastCyc, 1);
    checkOutput("r23_ovf", ovf, 0);
    checkOutput("r23_doneAll", done_all, 0);

    // Rate 7/8, full run of eight blocks.
    doReset();
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < 2; w++) begin
        applyStimulus(3'd2, 3'(b), b * 2 + w);
        expectWord(b * 2 + w, 3'(b), w == 1);
        idle(7);
      end
    end
    waitBeats(128, 100);
    idle(3);
    compareBeats("r78");
    checkOutput("r78_tlastCnt", tlastCnt, 8);
    checkOutput("r78_blkDoneCnt", blkDoneCnt, 8);
    checkOutput("r78_doneAll", done_all, 1);
    clearQueues();
    applyStimulus(3'd2, 3'd0, 5);
    idle(20);
    checkOutput("r78_extraBeats", capData.size(), 0);
    checkOutput("r78_extraOvf", ovf, 0);
    checkOutput("r78_extraTvalid", m_tvalid, 0);
    checkOutput("r78_doneAllHeld", done_all, 1);

    // Backpressure with a toggling sink.
    doReset();
    readyMode = 2;
    for (int k = 4; k < 8; k++) begin
      applyStimulus(3'd1, 3'd3, k);
      expectWord(k, 3'd3, k == 7);
    end
    waitBeats(32, 300);
    idle(3);
    compareBeats("bp");
    checkOutput("bp_stallSeen", stallCnt != 0, 1);
    checkOutput("bp_tlastCnt", tlastCnt, 1);
    checkOutput("bp_ovf", ovf, 0);

    // Full FIFO accepts a word when the head pops in the same cycle.
    readyMode = 0;
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(3'd1, 3'd4, k);
      expectWord(k, 3'd4, k == 3);
    end
    idle(3);
    checkOutput("fp_fifoCount", dut.u_fifo.count, 4);
    checkOutput("fp_noBeats", capData.size(), 0);
    checkOutput("fp_ovfBefore", ovf, 0);
    readyMode = 1;
    c = 0;
    while (capData.size() < 7 && c < 50) begin
      idle(1);
      c++;
    end
    checkOutput("fp_reachBeat7", capData.size(), 7);
    applyStimulus(3'd1, 3'd4, 5);
    expectWord(5, 3'd4, 1'b0);
    waitBeats(48, 200);
    idle(3);
    compareBeats("fp");
    checkOutput("fp_ovfAfter", ovf, 0);
    checkOutput("fp_tlastCnt", tlastCnt, 1);

    // Overflow: six words into a stalled sink; the sixth is dropped.
    readyMode = 0;
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(3'd1, 3'd2, k);
    for (int k = 0; k < 5; k++) expectWord(k, 3'd2, k == 3);
    idle(3);
    checkOutput("ov_ovf", ovf, 1);
    checkOutput("ov_noBeats", capData.size(), 0);
    readyMode = 1;
    waitBeats(40, 200);
    idle(10);
    compareBeats("ov");
    checkOutput("ov_tlastCnt", tlastCnt, 1);

    // Invalid rate at block start.
    doReset();
    applyStimulus(3'd3, 3'd0, 1);
    idle(20);
    checkOutput("me_modeErr", mode_err, 1);
    checkOutput("me_noBeats", capData.size(), 0);
    checkOutput("me_tvalid", m_tvalid, 0);
    checkOutput("me_wcnt", dut.wcnt, 0);
    checkOutput("me_ovf", ovf, 0);
    for (int k = 8; k < 12; k++) begin
      applyStimulus(3'd1, 3'd6, k);
      expectWord(k, 3'd6, k == 11);
    end
    waitBeats(32, 200);
    idle(3);
    compareBeats("me");
    checkOutput("me_tlastCnt", tlastCnt, 1);

    // Reset at beat 5 of the second word, then a fresh block.
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(3'd1, 3'd1, k);
    c = 0;
    while (capData.size() < 13 && c < 100) begin
      idle(1);
      c++;
    end
    checkOutput("mr_reachBeat", capData.size(), 13);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkIdleOutputs("mr");
    clearQueues();
    idle(20);
    checkOutput("mr_flushed", capData.size(), 0);
    for (int k = 12; k < 16; k++) begin
      applyStimulus(3'd1, 3'd5, k);
      expectWord(k, 3'd5, k == 15);
    end
    waitBeats(32, 200);
    idle(3);
    compareBeats("mr");
    checkOutput("mr_tlastCnt", tlastCnt, 1);
    checkOutput("mr_blkDoneCnt", blkDoneCnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
